router_switch_xy: RTL and testbench
===================================

// Module: router_switch_xy
// PURPOSE
//  Parametrised successor router core: per-input XY route compute, per-output round-robin allocation,
//  N-way crossbar and optional output register stage. Supports NLOCAL concentrated local ports.
//  Sits between the input FIFOs (empty/read) and the output links (ena/busy) of each mesh node.
//  Drops U-turn flits and flags them.
// PARAMETERS
//  X_BITS   4   x-coordinate width
//  Y_BITS   4   y-coordinate width
//  L_BITS   1   local-port select width; NLOCAL = 2**L_BITS
//  DATA_W   40  flit width (hdr+payload+addr); dest addr in DATA_W low bits [ADDR_W-1:0]
//  OUT_REG  1   1: registered item_out/ena (1-cycle latency); 0: combinational (0 latency)
//  derived: ADDR_W = Y_BITS+X_BITS+L_BITS, NP = 4+NLOCAL; port index N=0,E=1,S=2,W=3,L0..=4..
// PORTS
//  clk       in   1            clock, rising edge
//  reset     in   1            asynchronous, active-high
//  id        in   Y_BITS+X_BITS  node coordinates {y,x}
//  item_in   in   NP*DATA_W    input flits, port p at [p*DATA_W +: DATA_W]
//  empty     in   NP           input FIFO empty, per port
//  read      out  NP           pop input FIFO p this cycle (combinational)
//  item_out  out  NP*DATA_W    output flits, same packing
//  ena       out  NP           item_out[o] valid, one cycle per flit
//  busy      in   NP           downstream o cannot accept a flit on the next ena slot
//  err       out  1            sticky: a U-turn flit was dropped
//  err_port  out  3..          index of first dropped-flit input (held while err=1)
// BEHAVIOUR
//  Reset (async): ena=0, item_out=0, err=0, err_port=0, all rr pointers=0; read forced 0 while reset=1.
//  Route (comb., per input p, dest {dy,dx,dl}): dx>x -> E; dx<x -> W; else dy>y -> S; dy<y -> N;
//   else local L(dl). X resolved strictly before Y (deadlock-free XY).
//  U-turn: route(p)==p (N->N, E->E, S->S, W->W, Lk->Lk) -> read[p]=1, no request, err set,
//   err_port latched only if err was 0. err clears only on reset.
//  Request req[p][o] = !empty[p] & route(p)==o & !busy[o] & o!=p.
//  Arbiter per output o: round-robin over the NP-1 other inputs, search starting at ptr[o];
//   on grant to p, ptr[o] <= next index after p (mod NP, skipping o). No grant -> ptr unchanged.
//  Each input has one route -> at most one grant per input; read[p] = OR of its grants | U-turn drop.
//  OUT_REG=1: granted flit registered; item_out[o], ena[o]=1 at t+1 for grant at t; no grant -> ena=0,
//   item_out holds last value. OUT_REG=0: same-cycle, item_out=0 when no grant.
//  busy at cycle t gates grants at t only; no internal buffering, no back-pressure loss:
//   a flit is popped (read) iff it is either forwarded or dropped.
//  Simultaneous: N requests to one free output -> exactly one grant; losers keep empty=0, retry next cycle.
//  Reset mid-operation: registered flit in flight is discarded (ena=0 immediately, async).
//  Throughput: up to NP flits/cycle (one per output), fully pipelined, no bubbles.
// STRUCTURE
//  Shared package/header: port index constants (PORT_N..PORT_L0), coordinate field slicing macros,
//   route-compute function xy_route(id, addr) returning port index.
//  Sub-module: rr_arb_n (parametrised NREQ round-robin arbiter, clk/reset, req/gnt vectors, internal ptr);
//   one instance per output. Crossbar = one-hot AND-OR mux per output.
// TESTING
//  1 id={2,2}, N input addr {2,5,0} -> E ena at t+1 with same flit; read[N]=1 at t; err=0.
//  2 id={2,2}, addr {2,2,1} from W -> L1; addr {4,2,0} from L0 -> S (X-equal, Y-first check).
//  3 N,S,W,L0 all target E every cycle for 8 cycles -> E grants rotate L0,N,S,W,... no input starves;
//    each input popped exactly twice.
//  4 busy[E]=1 for 3 cycles with pending flit -> read=0, ena[E]=0; busy drops -> flit out next cycle.
//  5 E input addr with dx>x (U-turn) -> read[E]=1, no ena anywhere, err=1, err_port=1; second
//    U-turn from W leaves err_port=1.
//  6 Assert reset while ena[S]=1 -> ena=0, item_out=0 asynchronously; after release rr order restarts at 0.

Source files
------------

// File: rtl/router_switch_xy_pkg.sv
// Shared definitions for the XY mesh router core.
//   PORT_*       : port index constants (N=0, E=1, S=2, W=3, local ports from 4 up)
//   get_field()  : extracts an unsigned bit field from a 32-bit zero-extended word
//   xy_route()   : dimension-ordered route compute, returns the output port index
package router_switch_xy_pkg;

  localparam int PORT_N  = 0;
  localparam int PORT_E  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_W  = 3;
  localparam int PORT_L0 = 4;

  function automatic int get_field(logic [31:0] v, int lsb, int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return int'((v >> lsb) & m);
  endfunction

  // X is resolved completely before Y; this ordering keeps the mesh deadlock free.
  function automatic int xy_route(int x, int y, int dx, int dy, int dl);
    if (dx > x)      return PORT_E;
    else if (dx < x) return PORT_W;
    else if (dy > y) return PORT_S;
    else if (dy < y) return PORT_N;
    else             return PORT_L0 + dl;
  endfunction

endpackage

// File: rtl/router_switch_xy_arb.sv
// rr_arb_n: round-robin arbiter for one router output.
//   clk, reset : clock, asynchronous active-high reset (pointer returns to 0)
//   req        : NREQ request lines, one per input port
//   gnt        : one-hot grant (all zero when nothing requests)
// The search starts at the pointer; after a grant the pointer moves to the
// index after the winner, stepping over SKIP (the output's own input port,
// which never requests because U-turns are dropped upstream).
module rr_arb_n #(
  parameter int NREQ = 6,
  parameter int SKIP = 0,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;
  int            nxt;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    nxt     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        nxt      = (int'(idx) + 1) % NREQ;
        if (nxt == SKIP) nxt = (nxt + 1) % NREQ;
        ptr_nxt  = PW'(nxt);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nxt;
  end

endmodule

// File: rtl/router_switch_xy.sv
// router_switch_xy: mesh router core with XY routing, per-output round-robin
// allocation, one-hot AND-OR crossbar and optional output register.
//   clk, reset : clock, asynchronous active-high reset
//   id         : node coordinates {y,x}
//   item_in    : NP input flits, port p at [p*DATA_W +: DATA_W]; dest {dy,dx,dl} in low bits
//   empty      : per-input FIFO empty
//   read       : per-input FIFO pop (combinational; forwarded or dropped)
//   item_out   : NP output flits, same packing
//   ena        : per-output flit valid
//   busy       : per-output downstream back-pressure, gates grants this cycle
//   err        : sticky, a U-turn flit was dropped
//   err_port   : input index of the first dropped flit
module router_switch_xy
  import router_switch_xy_pkg::*;
#(
  parameter int X_BITS  = 4,
  parameter int Y_BITS  = 4,
  parameter int L_BITS  = 1,
  parameter int DATA_W  = 40,
  parameter int OUT_REG = 1,
  localparam int NLOCAL = 2 ** L_BITS,
  localparam int NP     = 4 + NLOCAL,
  localparam int ADDR_W = Y_BITS + X_BITS + L_BITS,
  localparam int P_BITS = $clog2(NP)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Y_BITS+X_BITS-1:0] id,
  input  logic [NP*DATA_W-1:0]   item_in,
  input  logic [NP-1:0]          empty,
  output logic [NP-1:0]          read,
  output logic [NP*DATA_W-1:0]   item_out,
  output logic [NP-1:0]          ena,
  input  logic [NP-1:0]          busy,
  output logic                   err,
  output logic [P_BITS-1:0]      err_port
);

  localparam int AX = L_BITS;
  localparam int AY = L_BITS + X_BITS;

  logic [31:0]          id32;
  logic [31:0]          addr32;
  int                   route [NP];
  logic [NP-1:0]        uturn;
  logic [NP-1:0]        req [NP];
  logic [NP-1:0]        gnt [NP];
  logic [NP-1:0]        fwd;
  logic [NP-1:0]        xbar_ena;
  logic [NP*DATA_W-1:0] xbar_item;
  logic [P_BITS-1:0]    uturn_idx;

  assign id32 = 32'(id);

  always_comb begin
    addr32 = '0;
    uturn  = '0;
    for (int p = 0; p < NP; p++) begin
      addr32   = 32'(item_in[p*DATA_W +: ADDR_W]);
      route[p] = xy_route(get_field(id32, 0, X_BITS), get_field(id32, X_BITS, Y_BITS),
                          get_field(addr32, AX, X_BITS), get_field(addr32, AY, Y_BITS),
                          get_field(addr32, 0, L_BITS));
      uturn[p] = !empty[p] && (route[p] == p);
    end
    for (int o = 0; o < NP; o++) begin
      for (int p = 0; p < NP; p++) begin
        req[o][p] = !empty[p] && (route[p] == o) && !busy[o] && (o != p);
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_arb
    rr_arb_n #(.NREQ(NP), .SKIP(o)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[o]),
      .gnt   (gnt[o])
    );
  end

  // Every input has a single route, so it can win at most one output.
  always_comb begin
    fwd       = '0;
    xbar_ena  = '0;
    xbar_item = '0;
    for (int o = 0; o < NP; o++) begin
      xbar_ena[o] = |gnt[o];
      for (int p = 0; p < NP; p++) begin
        xbar_item[o*DATA_W +: DATA_W] = xbar_item[o*DATA_W +: DATA_W]
                                      | (item_in[p*DATA_W +: DATA_W] & {DATA_W{gnt[o][p]}});
        fwd[p] = fwd[p] | gnt[o][p];
      end
    end
  end

  assign read = reset ? '0 : (fwd | uturn);

  always_comb begin
    uturn_idx = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      if (uturn[p]) uturn_idx = P_BITS'(p);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_port <= '0;
    end else if (|uturn) begin
      err <= 1'b1;
      if (!err) err_port <= uturn_idx;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ena      <= '0;
        item_out <= '0;
      end else begin
        ena <= xbar_ena;
        for (int o = 0; o < NP; o++) begin
          if (xbar_ena[o]) item_out[o*DATA_W +: DATA_W] <= xbar_item[o*DATA_W +: DATA_W];
        end
      end
    end
  end else begin : g_out_comb
    assign ena      = xbar_ena;
    assign item_out = xbar_item;
  end

endmodule

// File: tb/tb_router_switch_xy.sv
// Testbench for router_switch_xy (default parameters, node id {2,2}).
// Input FIFOs are modelled as queues popped on the DUT's read strobe; a
// cycle-level model of the routing/arbitration rules is checked every cycle,
// and directed scenarios carry hand-computed literal expectations.
module tb_router_switch_xy;

  localparam int NP = 6;
  localparam int DW = 40;
  localparam int MY_X = 2;
  localparam int MY_Y = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        id;
  logic [NP*DW-1:0]  item_in;
  logic [NP-1:0]     empty;
  logic [NP-1:0]     read;
  logic [NP*DW-1:0]  item_out;
  logic [NP-1:0]     ena;
  logic [NP-1:0]     busy;
  logic              err;
  logic [2:0]        err_port;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [NP][$];
  logic [NP-1:0] rd_s = '0;
  int            pops [NP];

  // model state
  logic [NP-1:0]    m_ena;
  logic [NP*DW-1:0] m_item;
  logic             m_err;
  int               m_errp;
  int               m_ptr [NP];
  int               rt [NP];
  logic [NP-1:0]    e_read;
  logic [NP-1:0]    n_ena;
  logic [NP*DW-1:0] n_item;
  int               won;
  int               pp;
  logic             drop_any;
  int               drop_idx;

  router_switch_xy dut (
    .clk      (clk),
    .reset    (reset),
    .id       (id),
    .item_in  (item_in),
    .empty    (empty),
    .read     (read),
    .item_out (item_out),
    .ena      (ena),
    .busy     (busy),
    .err      (err),
    .err_port (err_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(int tag, int dy, int dx, int dl);
    logic [DW-1:0] f;
    f       = '0;
    f[39:9] = 31'(tag);
    f[8:5]  = 4'(dy);
    f[4:1]  = 4'(dx);
    f[0]    = 1'(dl);
    return f;
  endfunction

  function automatic int route_of(logic [DW-1:0] f);
    int dl, dx, dy;
    dl = int'(f[0]);
    dx = int'(f[4:1]);
    dy = int'(f[8:5]);
    if (dx > MY_X) return 1;
    if (dx < MY_X) return 3;
    if (dy > MY_Y) return 2;
    if (dy < MY_Y) return 0;
    return 4 + dl;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      empty[p] = (q[p].size() == 0);
      item_in[p*DW +: DW] = empty[p] ? '0 : q[p][0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (rd_s[p]) begin
        if (q[p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty port=%0d read=1 required=0", p);
        end else begin
          void'(q[p].pop_front());
          pops[p]++;
        end
      end
    end
    drive();
  endtask

  // Cycle model and per-cycle compare.
  always @(negedge clk) begin
    rd_s = read;
    if (reset) begin
      m_ena  = '0;
      m_item = '0;
      m_err  = 1'b0;
      m_errp = 0;
      for (int o = 0; o < NP; o++) m_ptr[o] = 0;
      chk("cyc_read_rst", read, 0);
      chk("cyc_ena_rst", ena, 0);
      chk("cyc_item_rst", item_out, 0);
      chk("cyc_err_rst", err, 0);
      chk("cyc_errp_rst", err_port, 0);
    end else begin
      e_read   = '0;
      n_ena    = '0;
      n_item   = m_item;
      drop_any = 1'b0;
      drop_idx = 0;
      for (int p = 0; p < NP; p++) begin
        rt[p] = (q[p].size() != 0) ? route_of(q[p][0]) : -1;
        if (rt[p] == p) begin
          e_read[p] = 1'b1;
          if (!drop_any) drop_idx = p;
          drop_any = 1'b1;
        end
      end
      for (int o = 0; o < NP; o++) begin
        won = -1;
        for (int k = 0; k < NP; k++) begin
          pp = (m_ptr[o] + k) % NP;
          if (won < 0 && pp != o && rt[pp] == o && !busy[o]) won = pp;
        end
        if (won >= 0) begin
          e_read[won]        = 1'b1;
          n_ena[o]           = 1'b1;
          n_item[o*DW +: DW] = q[won][0];
          m_ptr[o] = ((won + 1) % NP == o) ? (won + 2) % NP : (won + 1) % NP;
        end
      end
      chk("cyc_read", read, e_read);
      chk("cyc_ena", ena, m_ena);
      chk("cyc_item", item_out, m_item);
      chk("cyc_err", err, m_err);
      chk("cyc_errp", err_port, 3'(m_errp));
      m_ena  = n_ena;
      m_item = n_item;
      if (drop_any) begin
        if (!m_err) m_errp = drop_idx;
        m_err = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int t3_tags [8] = '{16, 10, 12, 14, 17, 11, 13, 15};

  initial begin
    reset = 1'b1;
    busy  = '0;
    id    = 8'h22;
    item_in = '0;
    empty = '1;
    for (int p = 0; p < NP; p++) pops[p] = 0;
    drive();
    #12;
    chk("rst_ena", ena, 0);
    chk("rst_item", item_out, 0);
    chk("rst_err", err, 0);
    chk("rst_read", read, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    step();

    // 1: N -> E
    q[0].push_back(mk(1, 2, 5, 0));
    drive();
    #1 chk("t1_read", read, 6'b000001);
    step();
    chk("t1_ena", ena, 6'b000010);
    chk("t1_item", item_out[1*DW +: DW], mk(1, 2, 5, 0));
    chk("t1_err", err, 0);

    // 2: W -> L1, L0 -> S
    q[3].push_back(mk(2, 2, 2, 1));
    q[4].push_back(mk(3, 4, 2, 0));
    drive();
    #1 chk("t2_read", read, 6'b011000);
    step();
    chk("t2_ena", ena, 6'b100100);
    chk("t2_item_l1", item_out[5*DW +: DW], mk(2, 2, 2, 1));
    chk("t2_item_s", item_out[2*DW +: DW], mk(3, 4, 2, 0));

    // 4: busy[E] holds a W flit for 3 cycles
    q[3].push_back(mk(4, 2, 5, 0));
    busy[1] = 1'b1;
    drive();
    for (int c = 0; c < 3; c++) begin
      #1 chk("t4_read_busy", read, 0);
      step();
      chk("t4_ena_busy", ena, 0);
    end
    busy[1] = 1'b0;
    #1 chk("t4_read_free", read, 6'b001000);
    step();
    chk("t4_ena_free", ena, 6'b000010);
    chk("t4_item", item_out[1*DW +: DW], mk(4, 2, 5, 0));

    // 3: N,S,W,L0 contend for E; pointer sits at L0 after the W grant above
    for (int p = 0; p < NP; p++) pops[p] = 0;
    q[0].push_back(mk(10, 2, 5, 0)); q[0].push_back(mk(11, 2, 5, 0));
    q[2].push_back(mk(12, 2, 5, 0)); q[2].push_back(mk(13, 2, 5, 0));
    q[3].push_back(mk(14, 2, 5, 0)); q[3].push_back(mk(15, 2, 5, 0));
    q[4].push_back(mk(16, 2, 5, 0)); q[4].push_back(mk(17, 2, 5, 0));
    drive();
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t3_ena", ena, 6'b000010);
      chk("t3_order", item_out[1*DW +: DW], mk(t3_tags[c], 2, 5, 0));
    end
    chk("t3_pops_n", pops[0], 2);
    chk("t3_pops_s", pops[2], 2);
    chk("t3_pops_w", pops[3], 2);
    chk("t3_pops_l0", pops[4], 2);

    // 5: U-turns from E then W
    q[1].push_back(mk(20, 2, 5, 0));
    drive();
    #1 chk("t5_read_e", read, 6'b000010);
    step();
    chk("t5_ena_e", ena, 0);
    chk("t5_err_e", err, 1);
    chk("t5_errp_e", err_port, 1);
    q[3].push_back(mk(21, 2, 0, 0));
    drive();
    #1 chk("t5_read_w", read, 6'b001000);
    step();
    chk("t5_ena_w", ena, 0);
    chk("t5_err_w", err, 1);
    chk("t5_errp_w", err_port, 1);

    // 6: reset while a flit is on S, then arbitration restarts from 0
    q[0].push_back(mk(30, 4, 2, 0));
    drive();
    step();
    chk("t6_ena_s", ena, 6'b000100);
    #2 reset = 1'b1;
    #1;
    chk("t6_ena_rst", ena, 0);
    chk("t6_item_rst", item_out, 0);
    chk("t6_err_rst", err, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    q[0].push_back(mk(31, 2, 5, 0));
    q[4].push_back(mk(32, 2, 5, 0));
    drive();
    step();
    chk("t6_rr_first", item_out[1*DW +: DW], mk(31, 2, 5, 0));
    step();
    chk("t6_rr_second", item_out[1*DW +: DW], mk(32, 2, 5, 0));
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
